// File: rtl/stm_swapchain_if.sv
// Segment-select bundle between stm_timer, the swap chain and the STM memory read stage.
// The master side drives requests and indices; the slave side returns the selected playback state.
interface stm_swapchain_if;
    logic        UPDATE_SETTINGS;
    logic        REQ_RD_SEGMENT;
    logic        TRANSITION_MODE;
    logic [15:0] REP [2];
    logic [12:0] IDX [2];
    logic        SEGMENT;
    logic [12:0] IDX_OUT;
    logic        STOP;
    logic        UPDATE_OUT;

    modport master (
        output UPDATE_SETTINGS, REQ_RD_SEGMENT, TRANSITION_MODE, REP, IDX,
        input  SEGMENT, IDX_OUT, STOP, UPDATE_OUT
    );

    modport slave (
        input  UPDATE_SETTINGS, REQ_RD_SEGMENT, TRANSITION_MODE, REP, IDX,
        output SEGMENT, IDX_OUT, STOP, UPDATE_OUT
    );
endinterface

// File: rtl/stm_swapchain.sv
// STM segment swap chain: picks the active segment index, switches immediately or on the next wrap,
// and counts segment loops so that finite playback can freeze once its repeat count is used up.
module stm_swapchain (
    input  logic             CLK,
    input  logic             RST_N,
    stm_swapchain_if.slave   bus
);
    typedef enum logic [1:0] {RUN_INF, RUN_FIN, WAIT_SYNC, STOPPED} state_t;
    localparam logic [15:0] REP_INF = 16'hFFFF;

    state_t      state_q, state_d, ret_q, ret_d;
    logic        seg_q, seg_d;
    logic [12:0] idx_out_q, idx_out_d;
    logic        stop_q, stop_d;
    logic        upd_q, upd_d;
    logic [15:0] loop_q, loop_d;
    logic [12:0] prev_q, prev_d;
    logic [15:0] rep_q, rep_d;
    logic        pend_seg_q, pend_seg_d;
    logic [15:0] pend_rep_q, pend_rep_d;

    logic [12:0] cur_idx;
    logic        wrap;
    logic        frozen;
    logic        do_entry;
    logic        entry_seg;
    logic [15:0] entry_rep;

    assign cur_idx = bus.IDX[seg_q];
    // The index holds each value for several cycles, so only a decrease marks a wrap.
    assign wrap    = cur_idx < prev_q;
    assign frozen  = (state_q == STOPPED) || (state_q == WAIT_SYNC && ret_q == STOPPED);

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch can be inferred.
        state_d    = state_q;
        ret_d      = ret_q;
        seg_d      = seg_q;
        stop_d     = stop_q;
        upd_d      = 1'b0;
        loop_d     = loop_q;
        rep_d      = rep_q;
        pend_seg_d = pend_seg_q;
        pend_rep_d = pend_rep_q;
        prev_d     = cur_idx;
        idx_out_d  = frozen ? idx_out_q : cur_idx;
        do_entry   = 1'b0;
        entry_seg  = seg_q;
        entry_rep  = rep_q;

        if (bus.UPDATE_SETTINGS) begin
            // A request outranks any wrap seen in the same cycle.
            if (!bus.TRANSITION_MODE) begin
                do_entry  = 1'b1;
                entry_seg = bus.REQ_RD_SEGMENT;
                entry_rep = bus.REP[bus.REQ_RD_SEGMENT];
            end else begin
                pend_seg_d = bus.REQ_RD_SEGMENT;
                pend_rep_d = bus.REP[bus.REQ_RD_SEGMENT];
                state_d    = WAIT_SYNC;
                if (state_q != WAIT_SYNC)
                    ret_d = state_q;
            end
        end else begin
            unique case (state_q)
                RUN_FIN: begin
                    if (wrap) begin
                        if (loop_q == rep_q) begin
                            state_d   = STOPPED;
                            stop_d    = 1'b1;
                            idx_out_d = idx_out_q;
                        end else if (loop_q != 16'hFFFF) begin
                            loop_d = loop_q + 16'd1;
                        end
                    end
                end
                WAIT_SYNC: begin
                    if (wrap) begin
                        do_entry  = 1'b1;
                        entry_seg = pend_seg_q;
                        entry_rep = pend_rep_q;
                    end
                end
                default: ;
            endcase
        end

        // Entry reloads prev from the new segment so the switch itself never looks like a wrap.
        if (do_entry) begin
            seg_d     = entry_seg;
            loop_d    = 16'd0;
            stop_d    = 1'b0;
            upd_d     = 1'b1;
            rep_d     = entry_rep;
            state_d   = (entry_rep == REP_INF) ? RUN_INF : RUN_FIN;
            prev_d    = bus.IDX[entry_seg];
            idx_out_d = bus.IDX[entry_seg];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= RUN_INF;
            ret_q      <= RUN_INF;
            seg_q      <= 1'b0;
            idx_out_q  <= 13'd0;
            stop_q     <= 1'b0;
            upd_q      <= 1'b0;
            loop_q     <= 16'd0;
            prev_q     <= 13'd0;
            rep_q      <= REP_INF;
            pend_seg_q <= 1'b0;
            pend_rep_q <= 16'd0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            seg_q      <= seg_d;
            idx_out_q  <= idx_out_d;
            stop_q     <= stop_d;
            upd_q      <= upd_d;
            loop_q     <= loop_d;
            prev_q     <= prev_d;
            rep_q      <= rep_d;
            pend_seg_q <= pend_seg_d;
            pend_rep_q <= pend_rep_d;
        end
    end

    assign bus.SEGMENT    = seg_q;
    assign bus.IDX_OUT    = idx_out_q;
    assign bus.STOP       = stop_q;
    assign bus.UPDATE_OUT = upd_q;
endmodule

// File: tb/tb_stm_swapchain.sv
// Bench for stm_swapchain: directed scenarios plus randomized traffic, all compared against a
// behavioural playback model through an expectation queue drained by an independent monitor.
module tb_stm_swapchain;
    logic CLK = 1'b0;
    logic RST_N;

    stm_swapchain_if bus();

    stm_swapchain dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic        seg;
        logic        stop;
        logic        upd;
        logic [12:0] idx;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Stimulus values driven onto the bus.
    bit          us, req, tm;
    logic [15:0] rep_v [2];
    int          idx_v [2];
    int          cyc_len [2];
    bit          rnd_hold;

    // Behavioural model: playback described as "wraps left before stop" rather than a loop counter.
    bit          m_seg, m_stop, m_upd, m_pending, m_pend_seg, m_finite;
    logic [15:0] m_pend_rep;
    int          m_idx_out, m_prev, m_left;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic model_reset();
        m_seg = 0; m_stop = 0; m_upd = 0; m_pending = 0; m_pend_seg = 0; m_finite = 0;
        m_pend_rep = 16'd0; m_idx_out = 0; m_prev = 0; m_left = 0;
    endtask

    task automatic enter(input bit s, input logic [15:0] r);
        m_seg     = s;
        m_idx_out = idx_v[s];
        m_prev    = idx_v[s];
        m_stop    = 0;
        m_upd     = 1;
        m_finite  = (r != 16'hFFFF);
        m_left    = int'(r) + 1;
        m_pending = 0;
    endtask

    // Advance the model by one clock given the inputs now on the bus, and queue the outcome.
    task automatic step_push();
        int cur;
        bit wrapped;
        m_upd   = 0;
        cur     = idx_v[m_seg];
        wrapped = cur < m_prev;
        if (us && !tm) begin
            enter(req, rep_v[req]);
        end else if (us) begin
            m_pending  = 1;
            m_pend_seg = req;
            m_pend_rep = rep_v[req];
            if (!m_stop) m_idx_out = cur;
            m_prev = cur;
        end else if (m_pending && wrapped) begin
            enter(m_pend_seg, m_pend_rep);
        end else begin
            if (!m_stop) begin
                if (m_finite && wrapped) begin
                    m_left--;
                    if (m_left == 0) m_stop = 1;
                    else m_idx_out = cur;
                end else begin
                    m_idx_out = cur;
                end
            end
            m_prev = cur;
        end
        exp_q.push_back('{seg: m_seg, stop: m_stop, upd: m_upd, idx: 13'(m_idx_out)});
    endtask

    task automatic apply();
        bus.UPDATE_SETTINGS = us;
        bus.REQ_RD_SEGMENT  = req;
        bus.TRANSITION_MODE = tm;
        bus.REP[0]          = rep_v[0];
        bus.REP[1]          = rep_v[1];
        bus.IDX[0]          = 13'(idx_v[0]);
        bus.IDX[1]          = 13'(idx_v[1]);
    endtask

    function automatic int nxt(input int s);
        if (rnd_hold && $urandom_range(0, 2) == 0) return idx_v[s];
        return (idx_v[s] >= cyc_len[s]) ? 0 : idx_v[s] + 1;
    endfunction

    task automatic cyc_set(input bit u, input bit r, input bit t, input int i0, input int i1);
        @(negedge CLK);
        us = u; req = r; tm = t;
        idx_v[0] = i0; idx_v[1] = i1;
        apply();
        step_push();
    endtask

    task automatic cyc(input bit u, input bit r, input bit t);
        int n0, n1;
        n0 = nxt(0);
        n1 = nxt(1);
        cyc_set(u, r, t, n0, n1);
    endtask

    task automatic run(input int n);
        repeat (n) cyc(0, 0, 0);
    endtask

    task automatic look();
        @(posedge CLK);
        #2;
    endtask

    // Monitor: every clock the DUT presents a new output word; compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb", {16'd0, bus.SEGMENT, bus.STOP, bus.UPDATE_OUT, bus.IDX_OUT}, {16'd0, e});
            end
        end
    end

    initial begin
        int ups;
        RST_N = 1'b0;
        us = 0; req = 0; tm = 0;
        rep_v[0] = 16'hFFFF; rep_v[1] = 16'hFFFF;
        idx_v[0] = 0; idx_v[1] = 0;
        cyc_len[0] = 7; cyc_len[1] = 1023;
        rnd_hold = 0;
        apply();
        model_reset();

        #13;
        check("rst_seg",  bus.SEGMENT,    0);
        check("rst_idx",  bus.IDX_OUT,    0);
        check("rst_stop", bus.STOP,       0);
        check("rst_upd",  bus.UPDATE_OUT, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        step_push();

        // Free run on segment 0, three or more wraps.
        for (int k = 0; k < 30; k++) begin
            cyc(0, 0, 0);
            look();
            check("free_stop", bus.STOP, 0);
        end
        check("free_seg", bus.SEGMENT, 0);

        // Immediate switch to segment 1.
        rep_v[1] = 16'hFFFF;
        cyc_set(1, 1, 0, 3, 500);
        look();
        check("imm_seg",  bus.SEGMENT,    1);
        check("imm_upd",  bus.UPDATE_OUT, 1);
        check("imm_idx",  bus.IDX_OUT,    500);
        check("imm_stop", bus.STOP,       0);
        run(5);

        // Sync switch back: request segment 1 while segment 0 shows 2.
        rep_v[0] = 16'hFFFF;
        cyc_set(1, 0, 0, 0, idx_v[1]);
        cyc(0, 0, 0);
        cyc_set(1, 1, 1, 2, idx_v[1]);
        ups = 0;
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0);
            look();
            ups += int'(bus.UPDATE_OUT);
            if (k == 5) check("sync_hold", bus.SEGMENT, 0);
            if (k == 6) check("sync_sw",   bus.SEGMENT, 1);
        end
        check("sync_pulses", ups, 1);

        // Finite repeat: REP=2 stops one cycle after the third wrap.
        rep_v[0] = 16'd2;
        cyc_set(1, 0, 0, 0, idx_v[1]);
        look();
        check("fin_upd", bus.UPDATE_OUT, 1);
        for (int k = 1; k <= 24; k++) begin
            cyc(0, 0, 0);
            look();
            if (k == 23) check("fin_prestop", bus.STOP, 0);
            if (k == 24) begin
                check("fin_stop", bus.STOP,    1);
                check("fin_idx",  bus.IDX_OUT, 7);
            end
        end
        run(6);
        look();
        check("fin_hold_stop", bus.STOP,    1);
        check("fin_hold_idx",  bus.IDX_OUT, 7);
        rep_v[0] = 16'hFFFF;
        cyc(1, 0, 0);
        look();
        check("resume_stop", bus.STOP,       0);
        check("resume_upd",  bus.UPDATE_OUT, 1);

        // Collision: sync request on the wrap cycle waits for the following wrap.
        rep_v[1] = 16'hFFFF;
        cyc_set(1, 0, 0, 0, idx_v[1]);
        run(7);
        cyc(1, 1, 1);
        look();
        check("col_nosw", bus.SEGMENT, 0);
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 0, 0);
            look();
            if (k == 7) check("col_wait", bus.SEGMENT, 0);
            if (k == 8) check("col_sw",   bus.SEGMENT, 1);
        end

        // Replacement request for segment 0 cancels the pending switch to 1.
        cyc_set(1, 0, 0, 0, idx_v[1]);
        cyc(0, 0, 0);
        cyc(1, 1, 1);
        cyc(0, 0, 0);
        cyc(1, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 0, 0);
            look();
            if (k == 4) begin
                check("repl_seg", bus.SEGMENT,    0);
                check("repl_upd", bus.UPDATE_OUT, 1);
            end
        end
        run(10);
        look();
        check("repl_stay", bus.SEGMENT, 0);

        // Reset while a sync request is pending.
        cyc_set(1, 0, 0, 0, idx_v[1]);
        cyc(0, 0, 0);
        cyc(1, 1, 1);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        @(posedge CLK);
        #3;
        RST_N = 1'b0;
        #1;
        check("arst_seg",  bus.SEGMENT,    0);
        check("arst_idx",  bus.IDX_OUT,    0);
        check("arst_stop", bus.STOP,       0);
        check("arst_upd",  bus.UPDATE_OUT, 0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        step_push();
        ups = 0;
        for (int k = 0; k < 20; k++) begin
            cyc(0, 0, 0);
            look();
            ups += int'(bus.UPDATE_OUT);
        end
        check("arst_nosw",  bus.SEGMENT, 0);
        check("arst_noupd", ups,         0);

        // Randomized traffic with held indices, live REP changes and CYCLE changes.
        rnd_hold   = 1;
        cyc_len[1] = 9;
        for (int k = 0; k < 600; k++) begin
            bit u, r, t;
            for (int s = 0; s < 2; s++) begin
                case ($urandom_range(0, 4))
                    0:       rep_v[s] = 16'd0;
                    1:       rep_v[s] = 16'd1;
                    2:       rep_v[s] = 16'd2;
                    3:       rep_v[s] = 16'd3;
                    default: rep_v[s] = 16'hFFFF;
                endcase
                if ($urandom_range(0, 63) == 0) cyc_len[s] = int'($urandom_range(2, 15));
            end
            u = ($urandom_range(0, 7) == 0);
            r = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            cyc(u, r, t);
        end

        repeat (3) @(posedge CLK);
        #2;
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/stm_swapchain.md
# stm_swapchain

Consumer of the per-segment STM indices produced by `stm_timer`. Selects which of the two STM segments drives the STM memory read address, and switches segment on request, either immediately or at the next wrap of the current segment's index. Counts segment loops against a programmed repeat count, and freezes playback (STOP) when a finite repeat count is exhausted. It sits between `stm_timer` and the STM memory read stage.

## Interface
- No parameters. Index width is fixed at 13 bits and repeat width at 16 bits, matching `settings::stm_settings_t`.

- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- UPDATE_SETTINGS  in  1  single-cycle pulse; latches REQ_RD_SEGMENT, TRANSITION_MODE and REP of the requested segment
- REQ_RD_SEGMENT  in  1  requested segment (0/1)
- TRANSITION_MODE  in  1  0 = IMMEDIATE, 1 = SYNC_IDX (switch at the next wrap of the current segment)
- REP[2]  in  16 each  loop count per segment; 16'hFFFF = infinite; otherwise playback stops after REP+1 wraps
- IDX[2]  in  13 each  free-running indices from `stm_timer`
- SEGMENT  out  1  active segment
- IDX_OUT  out  13  index of the active segment (frozen while STOP is asserted)
- STOP  out  1  finite playback exhausted
- UPDATE_OUT  out  1  one-cycle pulse on each segment entry or restart

## Operation
- States:
  - RUN_INF: infinite playback.
  - RUN_FIN: finite playback, counting loops.
  - WAIT_SYNC: a request is pending until the next wrap.
  - STOPPED: finite playback exhausted.
- Wrap detect:
  - `prev` register holds IDX[SEGMENT] from the previous cycle.
  - `wrap = IDX[SEGMENT] < prev`. This tolerates CYCLE changes and the multi-cycle hold of each index value.
  - `prev` is reloaded from the new segment on the cycle of a switch, so a switch never produces a spurious wrap.
- Entering a segment (called "entry"):
  - Set SEGMENT and clear `loop_cnt`.
  - Clear STOP and pulse UPDATE_OUT.
  - Next state is RUN_INF if the latched REP is FFFF, else RUN_FIN.
- UPDATE_SETTINGS with IMMEDIATE: entry happens on the next cycle, from any state. Requesting the currently active segment restarts it (loop count cleared, STOP cleared, UPDATE_OUT pulse).
- UPDATE_SETTINGS with SYNC_IDX:
  - The request is stored and the state moves to WAIT_SYNC.
  - The previous state is remembered, so RUN_FIN continues counting and STOPPED stays frozen while waiting.
  - On the first wrap of the current segment's raw IDX, entry occurs.
  - A new UPDATE_SETTINGS while in WAIT_SYNC replaces the pending request.
- RUN_FIN:
  - Each wrap increments `loop_cnt`.
  - On a wrap with `loop_cnt == REP`, go to STOPPED: STOP=1 and IDX_OUT holds its last pre-wrap value.
  - With REP=0, playback stops at the first wrap after entry.
- STOPPED: left only via UPDATE_SETTINGS.
- Simultaneous events:
  - UPDATE_SETTINGS beats a same-cycle wrap, whether the wrap would stop playback or fulfil a pending sync.
  - A SYNC request latched on a wrap cycle waits for the following wrap.
- Arithmetic: `loop_cnt` is 16 bits and saturates; it is not incremented in RUN_INF.

## Timing
- Reset values:
  - Outputs: SEGMENT=0, IDX_OUT=0, STOP=0, UPDATE_OUT=0.
  - Internal: state RUN_INF, `loop_cnt`=0, `prev`=0, pending request cleared.
- IDX_OUT = IDX[SEGMENT] registered, 1-cycle latency.
- IMMEDIATE: with UPDATE_SETTINGS at cycle N:
  - SEGMENT, UPDATE_OUT=1 and cleared STOP appear at N+1.
  - IDX_OUT at N+1 equals IDX[new] sampled at N.
- SYNC_IDX: with the wrap detected at cycle M (IDX[old] shows its post-wrap value at M):
  - SEGMENT switches and UPDATE_OUT pulses at M+1.
  - IDX_OUT at M+1 equals IDX[new] sampled at M.
- STOP rises at W+1 for the terminating wrap at cycle W; IDX_OUT at W+1 equals its value at W.
- Reset asserted mid-operation returns all outputs to reset values asynchronously. The pending request is discarded.

## Test plan
- Reset then free run:
  - Stimulus: IDX[0] counting 0..7 (CYCLE=7), REP[0]=FFFF.
  - Required: SEGMENT=0, IDX_OUT tracks IDX[0] with 1-cycle lag, STOP stays 0 across 3 wraps.
- IMMEDIATE switch:
  - Stimulus: request segment 1 at cycle N while IDX[0]=3 and IDX[1]=500.
  - Required: at N+1, SEGMENT=1, UPDATE_OUT=1, IDX_OUT=500, with no spurious loop count.
- SYNC_IDX switch:
  - Stimulus: request segment 1 while IDX[0]=2.
  - Required: SEGMENT stays 0 until the cycle after IDX[0] goes 7→0, then SEGMENT=1 with a single UPDATE_OUT pulse.
- Finite repeat:
  - Stimulus: request segment 0 IMMEDIATE with REP=2 (CYCLE=7).
  - Required: STOP=1 one cycle after the third wrap, IDX_OUT frozen at 7.
  - Follow-up: a later IMMEDIATE request clears STOP and resumes playback.
- Collision:
  - Stimulus: UPDATE_SETTINGS (SYNC, segment 1) lands in the same cycle as a wrap of segment 0.
  - Required: no switch on that wrap; the switch happens on the next wrap.
  - Then: a replacement request for segment 0 issued during WAIT_SYNC cancels the switch to 1.
- Reset mid-WAIT_SYNC:
  - Stimulus: drop RST_N while a request is pending.
  - Required: all outputs go to 0 immediately; after release no switch occurs on subsequent wraps.
